// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, stall encoding,
// reset address and the fetch FSM state type.
package if_fetch_pkg;

  localparam int unsigned N_INST_ADDR = 32;
  localparam int unsigned N_INST_DATA = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, masters the instruction bus (one
// outstanding request) and feeds the pc/inst pair to the IF/ID register.
module if_fetch #(
  parameter int unsigned N_INST_ADDR = if_fetch_pkg::N_INST_ADDR,
  parameter int unsigned N_INST_DATA = if_fetch_pkg::N_INST_DATA,
  parameter logic [N_INST_ADDR-1:0] RESET_PC = N_INST_ADDR'(if_fetch_pkg::RESET_PC_DEFAULT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [5:0]             i_stall,
  input  logic                   i_flush,
  input  logic [N_INST_ADDR-1:0] i_new_pc,
  input  logic                   i_branch_flag,
  input  logic [N_INST_ADDR-1:0] i_branch_target,
  output logic                   o_ibus_req,
  output logic [N_INST_ADDR-1:0] o_ibus_addr,
  input  logic                   i_ibus_ack,
  input  logic [N_INST_DATA-1:0] i_ibus_rdata,
  output logic [N_INST_ADDR-1:0] o_if_pc,
  output logic [N_INST_DATA-1:0] o_if_inst,
  output logic                   o_stallreq_if
);

  import if_fetch_pkg::*;

  fetch_state_e           state, state_d;
  logic [N_INST_ADDR-1:0] pc, pc_d;
  logic [N_INST_ADDR-1:0] br_target, br_target_d;
  logic                   br_pend, br_pend_d;
  logic [N_INST_DATA-1:0] hold, hold_d;
  logic [N_INST_ADDR-1:0] dis_addr, dis_addr_d;
  logic [N_INST_ADDR-1:0] next_pc;
  logic                   advance;

  // Only the fetch-stage bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^i_stall[5:1];

  // Fresh branch wins over an older latched one; sequential pc wraps.
  always_comb begin
    if (i_branch_flag) begin
      next_pc = i_branch_target;
    end else if (br_pend) begin
      next_pc = br_target;
    end else begin
      next_pc = pc + N_INST_ADDR'(4);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      br_target <= '0;
      br_pend   <= 1'b0;
      hold      <= '0;
      dis_addr  <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      br_target <= br_target_d;
      br_pend   <= br_pend_d;
      hold      <= hold_d;
      dis_addr  <= dis_addr_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    br_target_d = br_target;
    br_pend_d   = br_pend;
    hold_d      = hold;
    dis_addr_d  = dis_addr;
    advance     = 1'b0;

    case (state)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (i_ibus_ack) begin
          hold_d = i_ibus_rdata;
          if (i_stall[0] == NO_STOP) begin
            advance = 1'b1;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (i_stall[0] == NO_STOP) begin
          advance = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        if (i_ibus_ack) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A branch that cannot be taken this cycle is remembered until pc moves.
    if (advance) begin
      pc_d      = next_pc;
      br_pend_d = 1'b0;
    end else if (i_branch_flag) begin
      br_pend_d   = 1'b1;
      br_target_d = i_branch_target;
    end

    // Flush overrides everything; an unacked request must still drain.
    if (i_flush) begin
      pc_d      = i_new_pc;
      br_pend_d = 1'b0;
      hold_d    = '0;
      case (state)
        S_REQ: begin
          if (i_ibus_ack) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_DISCARD;
            dis_addr_d = pc;
          end
        end
        S_DISCARD: state_d = i_ibus_ack ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    o_ibus_req    = 1'b0;
    o_ibus_addr   = '0;
    o_if_pc       = '0;
    o_if_inst     = '0;
    o_stallreq_if = 1'b0;
    case (state)
      S_REQ: begin
        o_ibus_req    = 1'b1;
        o_ibus_addr   = pc;
        o_stallreq_if = !i_ibus_ack;
        if (i_ibus_ack) begin
          o_if_pc   = pc;
          o_if_inst = i_ibus_rdata;
        end
      end
      S_HOLD: begin
        o_if_pc   = pc;
        o_if_inst = hold;
      end
      S_DISCARD: begin
        o_ibus_req    = 1'b1;
        o_ibus_addr   = dis_addr;
        o_stallreq_if = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a linear step sequence with a scoreboard of
// expected fetch outputs and immediate assertions at every comparison.
module tb_if_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign ibus_rdata = mem_word(ibus_addr);

  if_fetch dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_new_pc        (new_pc),
    .i_branch_flag   (branch_flag),
    .i_branch_target (branch_target),
    .o_ibus_req      (ibus_req),
    .o_ibus_addr     (ibus_addr),
    .i_ibus_ack      (ibus_ack),
    .i_ibus_rdata    (ibus_rdata),
    .o_if_pc         (if_pc),
    .o_if_inst       (if_inst),
    .o_stallreq_if   (stallreq_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s step=%0d got=%08h exp=%08h", tag, step_no, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check the outputs.
  task automatic step(input logic r, input logic ack, input logic stop,
                      input logic br, input logic [31:0] tgt,
                      input logic fl, input logic [31:0] npc,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic e_sreq, input logic vld, input logic [31:0] vpc);
    exp_t e;
    @(negedge clk);
    step_no++;
    rst           = r;
    ibus_ack      = ack;
    stall         = {5'b0, stop};
    branch_flag   = br;
    branch_target = tgt;
    flush         = fl;
    new_pc        = npc;
    if (vld) sb.push_back('{pc: vpc, inst: mem_word(vpc)});
    #1;
    chk("req", 32'(ibus_req), 32'(e_req));
    if (e_req) chk("addr", ibus_addr, e_addr);
    chk("stallreq", 32'(stallreq_if), 32'(e_sreq));
    if (vld) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_inst", if_inst, e.inst);
      end
    end else begin
      chk("if_pc_nop", if_pc, 32'h0);
      chk("if_inst_nop", if_inst, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag = 1'b0; branch_target = '0; ibus_ack = 1'b0;
    repeat (2) @(posedge clk);
    //   rst ack stp br tgt            fl npc            req addr           sreq vld pc
    // Reset state: idle cycle with all outputs low
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 0, 32'h0);
    // Zero-wait fetch stream
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 1, 32'h0);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          0, 1, 32'h4);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h8,          0, 1, 32'h8);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'hC,          0, 1, 32'hC);
    // Ack delayed 3 cycles at 0x10 with a branch to 0x100 during the wait
    step(0, 0, 0, 1, 32'h100,        0, 32'h0,          1, 32'h10,         1, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h10,         1, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h10,         1, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h10,         0, 1, 32'h10);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h100,        0, 1, 32'h100);
    // Stall on the ack of 0x104: word held, stray ack ignored
    step(0, 1, 1, 0, 32'h0,          0, 32'h0,          1, 32'h104,        0, 1, 32'h104);
    step(0, 1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 1, 32'h104);
    step(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 1, 32'h104);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h108,        0, 1, 32'h108);
    // Flush to 0x180 with unacked 0x10C and a simultaneous branch
    step(0, 0, 0, 1, 32'h200,        1, 32'h180,        1, 32'h10C,        1, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h10C,        1, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h10C,        1, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h180,        0, 1, 32'h180);
    // Flush to the top of the address space, then wrap to zero
    step(0, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  1, 32'h184,        1, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h184,        1, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'hFFFF_FFFC,  0, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 1, 32'h0);
    // Reset in the middle of an outstanding request at 0x4
    step(1, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          1, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0, 1, 32'h0);
    step(0, 1, 0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          0, 1, 32'h4);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and acts as master on the instruction bus.
- Sources the fetch-side pc/inst pair consumed by the IF/ID pipeline register.
- Honours the pipeline-control stall vector and flush.
- Raises a stall request to pipeline control while a bus fetch is outstanding.

Parameters:
- N_INST_ADDR, 32, instruction address width.
- N_INST_DATA, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_stall  in  6  pipeline stall vector; bit0 = STOP freezes fetch.
- i_flush  in  1  pipeline flush (exception/eret).
- i_new_pc  in  N_INST_ADDR  restart address, valid with i_flush.
- i_branch_flag  in  1  ID resolved a taken branch/jump this cycle.
- i_branch_target  in  N_INST_ADDR  target, valid with i_branch_flag.
- o_ibus_req  out  1  fetch request.
- o_ibus_addr  out  N_INST_ADDR  fetch address.
- i_ibus_ack  in  1  read data valid; completes the request.
- i_ibus_rdata  in  N_INST_DATA  instruction word.
- o_if_pc  out  N_INST_ADDR  pc to the IF/ID register.
- o_if_inst  out  N_INST_DATA  instruction to the IF/ID register.
- o_stallreq_if  out  1  stall request to pipeline control.

Behaviour:
- Reset (sync, i_rst=1 at edge):
  - pc=RESET_PC, state=S_IDLE, branch-pending cleared.
  - All outputs 0 in the following cycle.
  - Reset during an outstanding request abandons it; the bus must tolerate this.
- States:
  - S_IDLE: one cycle after reset, req=0, then go to S_REQ.
  - S_REQ: req=1, addr=pc.
  - S_HOLD: word fetched, pipeline stalled.
  - S_DISCARD: flushed request still draining.
- Bus protocol:
  - At most one outstanding request.
  - req/addr stay stable from assertion until the ack cycle.
  - Ack is accepted only while req=1. Ack while req=0 is ignored.
  - Zero-wait ack gives 1 instruction/cycle.
- Output mux (combinational from state):
  - S_REQ with ack: o_if_pc=pc, o_if_inst=rdata.
  - S_HOLD: o_if_pc=pc, o_if_inst=hold buffer.
  - Otherwise: both 0 (nop).
- o_stallreq_if=1 when (S_REQ and !ack) or S_DISCARD; otherwise 0.
- S_REQ + ack:
  - Capture rdata into the hold buffer.
  - If i_stall[0]=NO_STOP: pc<=next_pc, stay in S_REQ.
  - Else: go to S_HOLD, pc unchanged.
- S_HOLD: when i_stall[0]=NO_STOP, pc<=next_pc and go to S_REQ.
- next_pc:
  - Branch target if i_branch_flag or branch-pending; else pc+4.
  - pc+4 wraps modulo 2^N_INST_ADDR (FFFF_FFFC -> 0000_0000).
  - Using next_pc clears branch-pending.
- Branch while pc cannot advance this cycle (no ack, or stalled): latch target, set branch-pending. A later branch overwrites the latched target.
- Flush (highest priority, beats branch and stall):
  - pc<=i_new_pc, branch-pending cleared, hold buffer dropped.
  - S_REQ without ack: go to S_DISCARD, keep req/addr at the old pc.
  - S_REQ with ack same cycle: data dropped, go to S_REQ at i_new_pc.
  - S_HOLD/S_IDLE: go to S_REQ at i_new_pc.
- S_DISCARD:
  - Outputs nop, req=1 at the old address.
  - On ack: drop data, go to S_REQ with addr=pc (the flush target).
  - A further flush in S_DISCARD only updates pc.
- pc is never forced to alignment; alignment faults are detected downstream.

Decomposition:
- Shared defines package holds: N_INST_ADDR, N_INST_DATA, STOP/NO_STOP, the RESET_PC default, and the fetch_state_e enum (S_IDLE, S_REQ, S_HOLD, S_DISCARD).
- Single module, no sub-module. next_pc is a local always_comb.

Test Plan:
- Reset, then ack tied 1, no stall -> req rises cycle 2; o_if_pc 0,4,8,C on consecutive cycles with matching rdata.
- Ack delayed 3 cycles at pc=8 -> o_stallreq_if=1 for 3 cycles, addr held at 8, outputs 0; pc 8 presented on the ack cycle.
- i_stall[0]=STOP for 2 cycles on ack at pc=4 -> S_HOLD; pc 4 and its word held constant; fetch of 8 issues after release.
- Branch to 0x100 asserted while fetch at pc=0x10 is waiting for ack -> after 0x10 completes, next addr=0x100, not 0x14.
- Flush with i_new_pc=0x180 while request at 0x20 is unacked -> req stays at 0x20 until ack, data dropped with outputs 0; next req addr=0x180. Simultaneous branch is ignored.
- pc=FFFF_FFFC fetched with no branch -> next addr 0000_0000. i_rst mid-request -> req=0 and pc=RESET_PC next cycle.
